// File: rtl/datapath_pkg.sv
// Shared constants for the pratica2 datapath: bus select codes, ALU opcodes
// and fixed field positions.
package datapath_pkg;

   localparam logic [3:0] SEL_R0  = 4'd0;
   localparam logic [3:0] SEL_R1  = 4'd1;
   localparam logic [3:0] SEL_R2  = 4'd2;
   localparam logic [3:0] SEL_R3  = 4'd3;
   localparam logic [3:0] SEL_R4  = 4'd4;
   localparam logic [3:0] SEL_R5  = 4'd5;
   localparam logic [3:0] SEL_R6  = 4'd6;
   localparam logic [3:0] SEL_R7  = 4'd7;
   localparam logic [3:0] SEL_G   = 4'd8;
   localparam logic [3:0] SEL_DIN = 4'd9;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLT = 3'd5;
   localparam logic [2:0] ALU_SLL = 3'd6;
   localparam logic [2:0] ALU_SRL = 3'd7;

   localparam int IR_W   = 10;
   localparam int PC_IDX = 7;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: result = op(a, b), truncated to DATA_W, no flags.
module datapath_alu
   import datapath_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
         ALU_SLL: result = a << b[3:0];
         ALU_SRL: result = a >> b[3:0];
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath for pratica2: bus mux, R0-R7 (R7 = PC), A/G around the
// ALU, IR, memory address/data/write registers and the 3-bit step counter.
module datapath_unit
   import datapath_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic [3:0]        mux_control,
   input  logic [7:0]        r_act,
   input  logic              a_act,
   input  logic              g_act,
   input  logic              ir_act,
   input  logic              addr_act,
   input  logic              dout_act,
   input  logic [2:0]        addsub,
   input  logic              incr_pc,
   input  logic              w_d,
   input  logic              counter_run,
   input  logic              counter_clear,
   output logic [2:0]        counter,
   output logic [IR_W-1:0]   ir,
   output logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] dout,
   output logic              w,
   output logic [DATA_W-1:0] bus
);

   logic [DATA_W-1:0] r [8];
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] g_reg;
   logic [DATA_W-1:0] alu_result;

   always_comb begin
      bus = '0;
      if (mux_control <= SEL_R7)
         bus = r[mux_control[2:0]];
      else if (mux_control == SEL_G)
         bus = g_reg;
      else if (mux_control == SEL_DIN)
         bus = din;
   end

   datapath_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a_reg),
      .b      (bus),
      .op     (addsub),
      .result (alu_result)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++)
            r[i] <= '0;
         a_reg   <= '0;
         g_reg   <= '0;
         ir      <= '0;
         addr    <= '0;
         dout    <= '0;
         w       <= 1'b0;
         counter <= 3'd0;
      end else begin
         for (int i = 0; i < 8; i++)
            if (r_act[i])
               r[i] <= bus;
         // An explicit PC write takes precedence; the increment is dropped.
         if (incr_pc && !r_act[PC_IDX])
            r[PC_IDX] <= r[PC_IDX] + DATA_W'(1);
         if (a_act)    a_reg <= bus;
         if (g_act)    g_reg <= alu_result;
         if (ir_act)   ir    <= din[IR_W-1:0];
         if (addr_act) addr  <= bus;
         if (dout_act) dout  <= bus;
         w <= w_d;
         if (counter_clear)
            counter <= 3'd0;
         else if (counter_run)
            counter <= counter + 3'd1;
      end
   end

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit against a behavioural register model.
module tb_datapath_unit;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  din;
   logic [3:0]    mux_control;
   logic [7:0]    r_act;
   logic          a_act, g_act, ir_act, addr_act, dout_act;
   logic [2:0]    addsub;
   logic          incr_pc, w_d, counter_run, counter_clear;
   logic [2:0]    counter;
   logic [9:0]    ir;
   logic [W-1:0]  addr, dout, bus;
   logic          w;

   int compared   = 0;
   int mismatched = 0;

   logic [W-1:0] m_r [8];
   logic [W-1:0] m_a, m_g, m_addr, m_dout;
   logic [9:0]   m_ir;
   logic         m_w;
   int           m_cnt;

   always #5 clock = ~clock;

   datapath_unit #(.DATA_W(W)) dut (
      .clock(clock), .reset(reset), .din(din), .mux_control(mux_control),
      .r_act(r_act), .a_act(a_act), .g_act(g_act), .ir_act(ir_act),
      .addr_act(addr_act), .dout_act(dout_act), .addsub(addsub),
      .incr_pc(incr_pc), .w_d(w_d), .counter_run(counter_run),
      .counter_clear(counter_clear), .counter(counter), .ir(ir),
      .addr(addr), .dout(dout), .w(w), .bus(bus)
   );

   function automatic logic [W-1:0] model_bus(input logic [3:0] sel);
      if (sel < 4'd8)  return m_r[sel[2:0]];
      if (sel == 4'd8) return m_g;
      if (sel == 4'd9) return din;
      return '0;
   endfunction

   function automatic logic [W-1:0] model_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned ua, ub, sh, res;
      ua = a; ub = b; sh = ub % 16;
      case (op)
         0: res = ua + ub;
         1: res = ua - ub;
         2: res = ua & ub;
         3: res = ua | ub;
         4: res = ua ^ ub;
         5: res = (ua < ub) ? 1 : 0;
         6: res = ua * (32'd1 << sh);
         default: res = ua / (32'd1 << sh);
      endcase
      return W'(res % 65536);
   endfunction

   task automatic idle();
      reset = 0; din = '0; mux_control = 4'd0; r_act = 8'd0;
      a_act = 0; g_act = 0; ir_act = 0; addr_act = 0; dout_act = 0;
      addsub = 3'd0; incr_pc = 0; w_d = 0; counter_run = 0; counter_clear = 0;
   endtask

   // One clock edge with the currently driven inputs; the model advances with it.
   task automatic apply();
      logic [W-1:0] b, na, ng, naddr, ndout;
      logic [W-1:0] nr [8];
      logic [9:0]   nir;
      logic         nw;
      int           ncnt;
      b = model_bus(mux_control);
      nr = m_r; na = m_a; ng = m_g; naddr = m_addr; ndout = m_dout;
      nir = m_ir; ncnt = m_cnt;
      nw = w_d;
      if (reset) begin
         for (int i = 0; i < 8; i++) nr[i] = '0;
         na = '0; ng = '0; naddr = '0; ndout = '0; nir = '0; nw = 0; ncnt = 0;
      end else begin
         for (int i = 0; i < 8; i++) if (r_act[i]) nr[i] = b;
         if (incr_pc && !r_act[7]) nr[7] = W'((int'(m_r[7]) + 1) % 65536);
         if (a_act)    na = b;
         if (g_act)    ng = model_alu(int'(addsub), m_a, b);
         if (ir_act)   nir = din[9:0];
         if (addr_act) naddr = b;
         if (dout_act) ndout = b;
         if (counter_clear)    ncnt = 0;
         else if (counter_run) ncnt = (m_cnt + 1) % 8;
      end
      @(posedge clock);
      m_r = nr; m_a = na; m_g = ng; m_addr = naddr; m_dout = ndout;
      m_ir = nir; m_w = nw; m_cnt = ncnt;
      #1;
   endtask

   task automatic load_reg(input int idx, input logic [W-1:0] val);
      idle(); din = val; mux_control = 4'd9; r_act[idx] = 1'b1;
      apply();
      idle();
   endtask

   task automatic test_reset();
      idle(); reset = 1; apply();
      idle(); din = 16'hBEEF; mux_control = 4'd9; r_act = 8'hFF; a_act = 1; g_act = 1;
      ir_act = 1; addr_act = 1; dout_act = 1; w_d = 1; counter_run = 1; incr_pc = 1;
      apply();
      reset = 1;
      apply();
      compared++; if (counter !== 3'd0) begin mismatched++; $display("FAIL reset_counter: got %0d expected 0", counter); end
      compared++; if (ir !== 10'd0) begin mismatched++; $display("FAIL reset_ir: got %h expected 0", ir); end
      compared++; if (addr !== '0) begin mismatched++; $display("FAIL reset_addr: got %h expected 0", addr); end
      compared++; if (dout !== '0) begin mismatched++; $display("FAIL reset_dout: got %h expected 0", dout); end
      compared++; if (w !== 1'b0) begin mismatched++; $display("FAIL reset_w: got %b expected 0", w); end
      idle();
      for (int s = 0; s < 16; s++) begin
         mux_control = 4'(s); #1;
         compared++;
         if (bus !== '0) begin mismatched++; $display("FAIL reset_bus sel=%0d: got %h expected 0", s, bus); end
      end
      mux_control = 4'd0;
   endtask

   task automatic test_immediate_load();
      idle(); din = 16'h002A; mux_control = 4'd9; r_act = 8'b0000_0010;
      apply();
      idle(); mux_control = 4'd1; #1;
      compared++; if (bus !== 16'h002A) begin mismatched++; $display("FAIL imm_load_r1: got %h expected 002a", bus); end
      mux_control = 4'd0; #1;
      compared++; if (bus !== 16'h0000) begin mismatched++; $display("FAIL imm_load_r0_untouched: got %h expected 0000", bus); end
   endtask

   task automatic alu_case(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] op,
                           input logic [W-1:0] exp, input string name);
      idle(); din = av; mux_control = 4'd9; a_act = 1; apply();
      idle(); din = bv; mux_control = 4'd9; addsub = op; g_act = 1; apply();
      idle(); mux_control = 4'd8; #1;
      compared++;
      if (bus !== exp) begin mismatched++; $display("FAIL %s: G got %h expected %h", name, bus, exp); end
   endtask

   task automatic test_alu();
      alu_case(16'd5, 16'd3, 3'b000, 16'h0008, "alu_add");
      alu_case(16'd0, 16'd1, 3'b001, 16'hFFFF, "alu_sub_wrap");
      alu_case(16'd1, 16'd4, 3'b110, 16'h0010, "alu_sll");
      alu_case(16'h8000, 16'd15, 3'b111, 16'h0001, "alu_srl");
      alu_case(16'd3, 16'd7, 3'b101, 16'h0001, "alu_slt_true");
      alu_case(16'hFFFF, 16'd7, 3'b101, 16'h0000, "alu_slt_unsigned");
      alu_case(16'hF0F0, 16'hFF00, 3'b100, 16'h0FF0, "alu_xor");
   endtask

   task automatic test_pc();
      load_reg(7, 16'hFFFF);
      incr_pc = 1; apply(); idle();
      mux_control = 4'd7; #1;
      compared++; if (bus !== 16'h0000) begin mismatched++; $display("FAIL pc_wrap: got %h expected 0000", bus); end
      idle(); din = 16'h0100; mux_control = 4'd9; r_act = 8'h80; incr_pc = 1; apply();
      idle(); mux_control = 4'd7; #1;
      compared++; if (bus !== 16'h0100) begin mismatched++; $display("FAIL pc_write_wins: got %h expected 0100", bus); end
      incr_pc = 1; apply(); idle(); mux_control = 4'd7; #1;
      compared++; if (bus !== 16'h0101) begin mismatched++; $display("FAIL pc_incr: got %h expected 0101", bus); end
   endtask

   task automatic test_memory();
      idle(); din = 16'h0055; mux_control = 4'd9; addr_act = 1; dout_act = 1; w_d = 1;
      apply();
      idle();
      compared++; if (addr !== 16'h0055) begin mismatched++; $display("FAIL mem_addr: got %h expected 0055", addr); end
      compared++; if (dout !== 16'h0055) begin mismatched++; $display("FAIL mem_dout: got %h expected 0055", dout); end
      compared++; if (w !== 1'b1) begin mismatched++; $display("FAIL mem_w_high: got %b expected 1", w); end
      apply();
      compared++; if (w !== 1'b0) begin mismatched++; $display("FAIL mem_w_low: got %b expected 0", w); end
   endtask

   task automatic test_counter();
      idle(); counter_clear = 1; apply();
      idle(); counter_run = 1;
      for (int i = 1; i <= 9; i++) begin
         apply();
         compared++;
         if (counter !== 3'(i % 8)) begin mismatched++; $display("FAIL counter_step%0d: got %0d expected %0d", i, counter, i % 8); end
      end
      counter_clear = 1; apply();
      compared++; if (counter !== 3'd0) begin mismatched++; $display("FAIL counter_clear_prio: got %0d expected 0", counter); end
      idle(); mux_control = 4'd12; #1;
      compared++; if (bus !== '0) begin mismatched++; $display("FAIL bus_sel12: got %h expected 0", bus); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         idle();
         reset         = ($urandom_range(0, 49) == 0);
         din           = W'($urandom);
         mux_control   = 4'($urandom_range(0, 15));
         r_act         = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
         a_act         = 1'($urandom);
         g_act         = 1'($urandom);
         ir_act        = 1'($urandom);
         addr_act      = 1'($urandom);
         dout_act      = 1'($urandom);
         addsub        = 3'($urandom);
         incr_pc       = 1'($urandom);
         w_d           = 1'($urandom);
         counter_run   = 1'($urandom);
         counter_clear = ($urandom_range(0, 7) == 0);
         #1;
         compared++;
         if (bus !== model_bus(mux_control)) begin
            mismatched++; $display("FAIL rnd_bus_pre n=%0d sel=%0d: got %h expected %h", n, mux_control, bus, model_bus(mux_control));
         end
         apply();
         compared++;
         if (counter !== 3'(m_cnt) || ir !== m_ir || addr !== m_addr || dout !== m_dout || w !== m_w) begin
            mismatched++;
            $display("FAIL rnd_regs n=%0d: got cnt=%0d ir=%h addr=%h dout=%h w=%b expected cnt=%0d ir=%h addr=%h dout=%h w=%b",
                     n, counter, ir, addr, dout, w, m_cnt, m_ir, m_addr, m_dout, m_w);
         end
         if (n % 8 == 0) begin
            idle();
            for (int s = 0; s < 10; s++) begin
               mux_control = 4'(s); #1;
               compared++;
               if (bus !== model_bus(4'(s))) begin
                  mismatched++; $display("FAIL rnd_sweep n=%0d sel=%0d: got %h expected %h", n, s, bus, model_bus(4'(s)));
               end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_a = '0; m_g = '0; m_addr = '0; m_dout = '0; m_ir = '0; m_w = 0; m_cnt = 0;
      idle();
      test_reset();
      test_immediate_load();
      test_alu();
      test_pc();
      test_memory();
      test_counter();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
